// File: rtl/alu_req_pkg.sv
// ============================================================================
// alu_req_pkg : request record, multiply command codes and classifier
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_req_pkg;

  localparam int REQ_DATA_WIDTH = 8;
  localparam int REQ_CMD_WIDTH  = 4;

  localparam logic [REQ_CMD_WIDTH-1:0] MUL_INC = 4'd9;
  localparam logic [REQ_CMD_WIDTH-1:0] MUL_SHL = 4'd10;

  typedef struct packed {
    logic                      mode;
    logic [REQ_CMD_WIDTH-1:0]  cmd;
    logic                      cin;
    logic [1:0]                inp_valid;
    logic [REQ_DATA_WIDTH-1:0] opa;
    logic [REQ_DATA_WIDTH-1:0] opb;
  } alu_req_t;

  // Multiplies only exist in arithmetic mode; the same codes are logical ops otherwise.
  function automatic logic is_mul(input alu_req_t req);
    return req.mode && ((req.cmd == MUL_INC) || (req.cmd == MUL_SHL));
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_req_issuer_if.sv
// ============================================================================
// alu_req_issuer_if : request handshake and ALU input port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface alu_req_issuer_if
  import alu_req_pkg::*;
#(
  parameter int DATA_WIDTH = REQ_DATA_WIDTH,
  parameter int CMD_WIDTH  = REQ_CMD_WIDTH,
  parameter int DEPTH      = 4
) ();

  logic                    flush;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_mode;
  logic [CMD_WIDTH-1:0]    req_cmd;
  logic                    req_cin;
  logic [1:0]              req_inp_valid;
  logic [DATA_WIDTH-1:0]   req_opa;
  logic [DATA_WIDTH-1:0]   req_opb;

  logic                    ce;
  logic                    cin;
  logic                    mode;
  logic [CMD_WIDTH-1:0]    cmd;
  logic [1:0]              inp_valid;
  logic [DATA_WIDTH-1:0]   opa;
  logic [DATA_WIDTH-1:0]   opb;
  logic                    drop;
  logic [$clog2(DEPTH):0]  fill_level;

  modport master (
    output flush, req_valid, req_mode, req_cmd, req_cin, req_inp_valid, req_opa, req_opb,
    input  req_ready, ce, cin, mode, cmd, inp_valid, opa, opb, drop, fill_level
  );

  modport slave (
    input  flush, req_valid, req_mode, req_cmd, req_cin, req_inp_valid, req_opa, req_opb,
    output req_ready, ce, cin, mode, cmd, inp_valid, opa, opb, drop, fill_level
  );

endinterface

`default_nettype wire

// File: rtl/alu_req_fifo.sv
// ============================================================================
// alu_req_fifo : DEPTH x alu_req_t synchronous FIFO with sync flush
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_req_fifo
  import alu_req_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               push,
  input  wire logic               pop,
  input  wire logic               flush,
  input  wire alu_req_t           wdata,
  output alu_req_t                rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_req_t             r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_do_push;
  logic                 w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  // Pointers are exactly PTR_W bits, so DEPTH being a power of two gives the wrap for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/alu_req_issuer.sv
// ============================================================================
// alu_req_issuer : queues ALU requests and issues one per cycle, spacing multiplies
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_req_issuer
  import alu_req_pkg::*;
#(
  parameter int DATA_WIDTH = REQ_DATA_WIDTH,
  parameter int CMD_WIDTH  = REQ_CMD_WIDTH,
  parameter int DEPTH      = 4,
  parameter int MUL_STALL  = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_req_issuer_if.slave  bus
);

  localparam int STALL_W = (MUL_STALL > 0) ? $clog2(MUL_STALL + 1) : 1;

  alu_req_t               w_req;
  alu_req_t               w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_issue;

  alu_req_t               r_out;
  logic                   r_ce;
  logic                   r_drop;
  logic                   r_ready_en;
  logic [STALL_W-1:0]     r_stall;

  assign w_req.mode      = bus.req_mode;
  assign w_req.cmd       = REQ_CMD_WIDTH'(bus.req_cmd);
  assign w_req.cin       = bus.req_cin;
  assign w_req.inp_valid = bus.req_inp_valid;
  assign w_req.opa       = REQ_DATA_WIDTH'(bus.req_opa);
  assign w_req.opb       = REQ_DATA_WIDTH'(bus.req_opb);

  // Readiness is held off until the first edge after reset release.
  assign bus.req_ready = r_ready_en && !w_full && !bus.flush;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_push        = w_accept && (bus.req_inp_valid != 2'b00);
  assign w_issue       = !w_empty && (r_stall == '0) && !bus.flush;

  alu_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_issue),
    .flush (bus.flush),
    .wdata (w_req),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out      <= '0;
      r_ce       <= 1'b0;
      r_drop     <= 1'b0;
      r_ready_en <= 1'b0;
      r_stall    <= '0;
    end else begin
      r_ready_en <= 1'b1;
      r_drop     <= w_accept && (bus.req_inp_valid == 2'b00);
      if (bus.flush) begin
        r_ce            <= 1'b0;
        r_out.inp_valid <= 2'b00;
        r_stall         <= '0;
      end else if (w_issue) begin
        r_ce    <= 1'b1;
        r_out   <= w_head;
        r_stall <= is_mul(w_head) ? STALL_W'(MUL_STALL) : '0;
      end else begin
        r_ce            <= 1'b0;
        r_out.inp_valid <= 2'b00;
        if (r_stall != '0) r_stall <= r_stall - 1'b1;
      end
    end
  end

  assign bus.ce         = r_ce;
  assign bus.cin        = r_out.cin;
  assign bus.mode       = r_out.mode;
  assign bus.cmd        = CMD_WIDTH'(r_out.cmd);
  assign bus.inp_valid  = r_out.inp_valid;
  assign bus.opa        = DATA_WIDTH'(r_out.opa);
  assign bus.opb        = DATA_WIDTH'(r_out.opb);
  assign bus.drop       = r_drop;
  assign bus.fill_level = w_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_issuer.sv
// ============================================================================
// tb_alu_req_issuer : scoreboard bench for alu_req_issuer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_req_issuer;
  import alu_req_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b0;
  int       n_checks = 0;
  int       n_fail   = 0;
  alu_req_t sb[$];
  alu_req_t mon_got;
  alu_req_t mon_exp;

  alu_req_issuer_if #(.DATA_WIDTH(8), .CMD_WIDTH(4), .DEPTH(4)) bus();

  alu_req_issuer #(
    .DATA_WIDTH (8),
    .CMD_WIDTH  (4),
    .DEPTH      (4),
    .MUL_STALL  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Every issue cycle must match the oldest outstanding request; idle cycles carry no operands.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_checks++;
      if (bus.ce === 1'b1) begin
        mon_got.mode      = bus.mode;
        mon_got.cmd       = bus.cmd;
        mon_got.cin       = bus.cin;
        mon_got.inp_valid = bus.inp_valid;
        mon_got.opa       = bus.opa;
        mon_got.opb       = bus.opb;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_issue: got %h with empty scoreboard at %0t", mon_got, $time);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL issue_data: got %h expected %h at %0t", mon_got, mon_exp, $time);
          end
        end
      end else if (bus.ce !== 1'b0 || bus.inp_valid !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_cycle: ce=%b inp_valid=%b expected ce=0 inp_valid=00 at %0t",
                 bus.ce, bus.inp_valid, $time);
      end
    end
  end

  task automatic offer(input logic v, input logic md, input logic [3:0] cm, input logic ci,
                       input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b,
                       output logic acc);
    alu_req_t e;
    bus.req_valid     = v;
    bus.req_mode      = md;
    bus.req_cmd       = cm;
    bus.req_cin       = ci;
    bus.req_inp_valid = iv;
    bus.req_opa       = a;
    bus.req_opb       = b;
    #1;
    acc = v && (bus.req_ready === 1'b1);
    if (acc && iv != 2'b00) begin
      e.mode = md; e.cmd = cm; e.cin = ci; e.inp_valid = iv; e.opa = a; e.opb = b;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    logic acc;
    offer(1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 8'h00, 8'h00, acc);
  endtask

  task automatic test_reset();
    logic acc;
    @(negedge clk);
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL por_ce: got %b expected 0", bus.ce); end
    n_checks++; if (bus.inp_valid !== 2'b00) begin n_fail++; $display("FAIL por_inp_valid: got %b expected 00", bus.inp_valid); end
    n_checks++; if ({bus.mode, bus.cmd, bus.cin, bus.opa, bus.opb} !== 22'h0) begin n_fail++; $display("FAIL por_data: got %h expected 0", {bus.mode, bus.cmd, bus.cin, bus.opa, bus.opb}); end
    n_checks++; if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL por_drop: got %b expected 0", bus.drop); end
    n_checks++; if (bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL por_fill: got %0d expected 0", bus.fill_level); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL por_ready: got %b expected 0", bus.req_ready); end
    rst = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early: got %b expected 0", bus.req_ready); end
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b expected 1", bus.req_ready); end

    // A multiply stall lets three requests pile up behind it before reset hits.
    offer(1'b1, 1'b1, MUL_INC, 1'b0, 2'b11, 8'h12, 8'h03, acc);
    @(negedge clk); offer(1'b1, 1'b0, 4'd1, 1'b0, 2'b11, 8'hA1, 8'hB1, acc);
    @(negedge clk); offer(1'b1, 1'b0, 4'd2, 1'b1, 2'b01, 8'hA2, 8'hB2, acc);
    @(negedge clk); offer(1'b1, 1'b0, 4'd3, 1'b0, 2'b10, 8'hA3, 8'hB3, acc);
    @(negedge clk);
    n_checks++; if (bus.fill_level !== 3'd3) begin n_fail++; $display("FAIL mid_fill_before: got %0d expected 3", bus.fill_level); end
    idle();
    rst = 1'b0;
    #1;
    sb.delete();
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL mid_ce: got %b expected 0", bus.ce); end
    n_checks++; if (bus.inp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_inp_valid: got %b expected 00", bus.inp_valid); end
    n_checks++; if (bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL mid_fill: got %0d expected 0", bus.fill_level); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b expected 0", bus.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL post_rst_stale_issue: got ce=%b expected 0", bus.ce); end
    end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_single();
    logic acc;
    @(negedge clk); offer(1'b1, 1'b1, 4'd0, 1'b0, 2'b11, 8'h0F, 8'h01, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b expected 1", acc); end
    @(negedge clk);
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL single_early: got ce=%b expected 0", bus.ce); end
    idle();
    @(negedge clk);
    n_checks++; if (bus.ce !== 1'b1) begin n_fail++; $display("FAIL single_ce: got %b expected 1", bus.ce); end
    n_checks++; if ({bus.opa, bus.opb, bus.cmd} !== {8'h0F, 8'h01, 4'd0}) begin n_fail++; $display("FAIL single_ops: got %h expected 0f010", {bus.opa, bus.opb, bus.cmd}); end
    @(negedge clk);
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL single_ce_off: got %b expected 0", bus.ce); end
    n_checks++; if (bus.opa !== 8'h0F) begin n_fail++; $display("FAIL single_hold_opa: got %h expected 0f", bus.opa); end
  endtask

  task automatic test_back_to_back();
    logic acc;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        n_checks++; if (bus.ce !== 1'b1) begin n_fail++; $display("FAIL b2b_ce[%0d]: got %b expected 1", i, bus.ce); end
      end
      if (i < 4) offer(1'b1, 1'b0, 4'(i + 1), i[0], 2'b11, 8'(8'h11 * (i + 1)), 8'(8'h80 + i), acc);
      else idle();
    end
  endtask

  task automatic test_mul_spacing();
    logic       acc;
    logic [3:0] pat;
    pat = 4'b1001;
    @(negedge clk); offer(1'b1, 1'b1, MUL_INC, 1'b0, 2'b11, 8'h03, 8'h05, acc);
    @(negedge clk); offer(1'b1, 1'b0, 4'd0, 1'b0, 2'b11, 8'hF0, 8'h3C, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) idle();
      n_checks++; if (bus.ce !== pat[3 - i]) begin n_fail++; $display("FAIL mul_ce[%0d]: got %b expected %b", i, bus.ce, pat[3 - i]); end
    end
  endtask

  task automatic test_full_backpressure();
    logic acc;
    @(negedge clk); offer(1'b1, 1'b1, MUL_INC, 1'b0, 2'b11, 8'h21, 8'h02, acc);
    @(negedge clk); offer(1'b1, 1'b1, MUL_SHL, 1'b1, 2'b11, 8'h22, 8'h03, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); offer(1'b1, 1'b0, 4'(i + 5), 1'b0, 2'b11, 8'(8'hC0 + i), 8'(8'hD0 + i), acc);
      n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL full_accept[%0d]: got %b expected 1", i, acc); end
    end
    @(negedge clk);
    n_checks++; if (bus.fill_level !== 3'd4) begin n_fail++; $display("FAIL full_level: got %0d expected 4", bus.fill_level); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", bus.req_ready); end
    offer(1'b1, 1'b0, 4'd15, 1'b1, 2'b11, 8'hEE, 8'hEF, acc);
    n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL full_fifth_accept: got %b expected 0", acc); end
    @(negedge clk);
    n_checks++; if (bus.fill_level !== 3'd4) begin n_fail++; $display("FAIL full_fifth_level: got %0d expected 4", bus.fill_level); end
    idle();
    for (int i = 0; i < 40 && (sb.size() != 0 || bus.fill_level != 0); i++) @(negedge clk);
    n_checks++; if (sb.size() != 0 || bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL full_drain: got %0d pending, fill %0d expected 0", sb.size(), bus.fill_level); end
  endtask

  task automatic test_drop();
    logic acc;
    @(negedge clk); offer(1'b1, 1'b1, 4'd1, 1'b0, 2'b00, 8'h55, 8'hAA, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL drop_accept: got %b expected 1", acc); end
    @(negedge clk);
    n_checks++; if (bus.drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b expected 1", bus.drop); end
    n_checks++; if (bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL drop_fill: got %0d expected 0", bus.fill_level); end
    idle();
    @(negedge clk);
    n_checks++; if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL drop_width: got %b expected 0", bus.drop); end
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL drop_ce: got %b expected 0", bus.ce); end
  endtask

  task automatic test_flush();
    logic acc;
    @(negedge clk); offer(1'b1, 1'b1, MUL_SHL, 1'b0, 2'b11, 8'h31, 8'h04, acc);
    @(negedge clk); offer(1'b1, 1'b0, 4'd4, 1'b0, 2'b11, 8'h41, 8'h51, acc);
    @(negedge clk); offer(1'b1, 1'b0, 4'd5, 1'b1, 2'b11, 8'h42, 8'h52, acc);
    @(negedge clk); offer(1'b1, 1'b0, 4'd6, 1'b0, 2'b11, 8'h43, 8'h53, acc);
    @(negedge clk);
    n_checks++; if (bus.fill_level !== 3'd3) begin n_fail++; $display("FAIL flush_pre_fill: got %0d expected 3", bus.fill_level); end
    bus.flush = 1'b1;
    offer(1'b1, 1'b0, 4'd7, 1'b0, 2'b11, 8'h44, 8'h54, acc);
    n_checks++; if (acc !== 1'b0) begin n_fail++; $display("FAIL flush_offer_accept: got %b expected 0", acc); end
    @(negedge clk);
    sb.delete();
    n_checks++; if (bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL flush_fill: got %0d expected 0", bus.fill_level); end
    n_checks++; if (bus.ce !== 1'b0) begin n_fail++; $display("FAIL flush_ce: got %b expected 0", bus.ce); end
    n_checks++; if (bus.drop !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b expected 0", bus.drop); end
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    n_checks++; if (bus.ce !== 1'b0 || bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL flush_after: got ce=%b fill=%0d expected ce=0 fill=0", bus.ce, bus.fill_level); end
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      offer(($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom), 1'($urandom),
            2'($urandom), 8'($urandom), 8'($urandom), acc);
    end
    @(negedge clk); idle();
    for (int i = 0; i < 150 && (sb.size() != 0 || bus.fill_level != 0); i++) @(negedge clk);
    n_checks++; if (sb.size() != 0 || bus.fill_level !== 3'd0) begin n_fail++; $display("FAIL random_drain: got %0d pending, fill %0d expected 0", sb.size(), bus.fill_level); end
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_mode = 1'b0; bus.req_cmd = 4'd0; bus.req_cin = 1'b0;
    bus.req_inp_valid = 2'b00; bus.req_opa = 8'h00; bus.req_opb = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_mul_spacing();
    test_full_backpressure();
    test_drop();
    test_flush();
    test_random();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
